// File: rtl/muldiv_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : muldiv_pkg
//  Description : Shared types and constants for the iterative multiply/divide
//                execute stage (operation encoding, FSM states, div-by-zero
//                quotient value, op-class helper).
//  Revision    : 1.0 - initial release
// ============================================================================
package muldiv_pkg;

    // Operation encoding as presented on the op port; all operations unsigned.
    typedef enum logic [1:0] {
        OP_MUL   = 2'b00,
        OP_MULHU = 2'b01,
        OP_DIVU  = 2'b10,
        OP_REMU  = 2'b11
    } op_e;

    // Control states of the execute unit.
    typedef enum logic [1:0] {
        S_IDLE = 2'b00,
        S_CALC = 2'b01,
        S_WB   = 2'b10
    } state_e;

    // Quotient returned for a zero divisor; sliced down to the unit width.
    localparam logic [63:0] DIV0_QUOTIENT = '1;

    // True for the two multiply flavours, which share the product datapath.
    function automatic logic is_mul(input op_e op);
        return (op == OP_MUL) || (op == OP_MULHU);
    endfunction

endpackage : muldiv_pkg
`default_nettype wire

// File: rtl/muldiv_step.sv
`default_nettype none
// ============================================================================
//  Module      : muldiv_step
//  Description : Combinational single iteration of the multiply/divide
//                datapath. Multiply is a right-shifting shift-add over a
//                2*WIDTH product register; divide is restoring division that
//                produces one quotient bit per call.
//  Revision    : 1.0 - initial release
// ============================================================================
module muldiv_step
    import muldiv_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  op_e                  op,
    input  logic [WIDTH-1:0]     a,
    input  logic [WIDTH-1:0]     b,
    input  logic [2*WIDTH-1:0]   prod,
    input  logic [WIDTH-1:0]     quo,
    input  logic [WIDTH-1:0]     rem,
    output logic [2*WIDTH-1:0]   prod_nxt,
    output logic [WIDTH-1:0]     quo_nxt,
    output logic [WIDTH-1:0]     rem_nxt
);

    logic [WIDTH:0]   addend;
    logic [WIDTH:0]   sum;
    logic [WIDTH:0]   shifted;
    logic             ge;
    logic [WIDTH-1:0] rem_sub;

    // One iteration: only the registers belonging to the active op class move.
    always_comb begin
        prod_nxt = prod;
        quo_nxt  = quo;
        rem_nxt  = rem;

        // Shift-add: the multiplier sits in the low half and is consumed LSB
        // first; the carry of the upper-half add lands in the vacated MSB.
        addend = prod[0] ? {1'b0, a} : '0;
        sum    = {1'b0, prod[2*WIDTH-1:WIDTH]} + addend;

        // Restoring divide: bring the next dividend bit into the partial
        // remainder (one guard bit wide) and subtract if the divisor fits.
        // The difference is always below the divisor, so WIDTH bits suffice.
        shifted = {rem, quo[WIDTH-1]};
        ge      = (shifted >= {1'b0, b});
        rem_sub = shifted[WIDTH-1:0] - b;

        if (is_mul(op)) begin
            prod_nxt = {sum, prod[WIDTH-1:1]};
        end else begin
            quo_nxt = {quo[WIDTH-2:0], ge};
            rem_nxt = ge ? rem_sub : shifted[WIDTH-1:0];
        end
    end

endmodule : muldiv_step
`default_nettype wire

// File: rtl/muldiv_exec_unit.sv
`default_nettype none
// ============================================================================
//  Module      : muldiv_exec_unit
//  Description : Iterative unsigned multiply/divide execute stage. Accepts one
//                operation in IDLE, iterates WIDTH cycles in CALC, then spends
//                one WB cycle driving a single registered write-back beat
//                (wd3/wa3/we3) into the register bank.
//  Revision    : 1.0 - initial release
// ============================================================================
module muldiv_exec_unit
    import muldiv_pkg::*;
#(
    parameter int WIDTH  = 8,
    parameter int ADDR_W = 5
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [1:0]        op,
    input  logic [WIDTH-1:0]  rs1_val,
    input  logic [WIDTH-1:0]  rs2_val,
    input  logic [ADDR_W-1:0] rd_addr,
    output logic [WIDTH-1:0]  wd3,
    output logic [ADDR_W-1:0] wa3,
    output logic              we3,
    output logic              busy
);

    localparam int               CNT_W    = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(WIDTH - 1);

    state_e              state_q, state_d;
    logic [CNT_W-1:0]    cnt_q, cnt_d;
    op_e                 op_q, op_d;
    logic [WIDTH-1:0]    a_q, a_d;
    logic [WIDTH-1:0]    b_q, b_d;
    logic [ADDR_W-1:0]   rd_q, rd_d;
    logic [2*WIDTH-1:0]  prod_q, prod_d;
    logic [WIDTH-1:0]    quo_q, quo_d;
    logic [WIDTH-1:0]    rem_q, rem_d;
    logic [WIDTH-1:0]    wd3_q, wd3_d;
    logic [ADDR_W-1:0]   wa3_q, wa3_d;
    logic                we3_q, we3_d;

    logic [2*WIDTH-1:0]  prod_nxt;
    logic [WIDTH-1:0]    quo_nxt;
    logic [WIDTH-1:0]    rem_nxt;
    logic [WIDTH-1:0]    result;
    logic                accept;
    logic                last_step;

    assign in_ready  = (state_q == S_IDLE);
    assign busy      = (state_q != S_IDLE);
    assign accept    = in_valid && in_ready;
    assign last_step = (cnt_q == LAST_CNT);

    assign wd3 = wd3_q;
    assign wa3 = wa3_q;
    assign we3 = we3_q;

    muldiv_step #(
        .WIDTH    (WIDTH)
    ) u_step (
        .op       (op_q),
        .a        (a_q),
        .b        (b_q),
        .prod     (prod_q),
        .quo      (quo_q),
        .rem      (rem_q),
        .prod_nxt (prod_nxt),
        .quo_nxt  (quo_nxt),
        .rem_nxt  (rem_nxt)
    );

    // Result of the final iteration, taken from the step outputs so it can be
    // registered into wd3 on the same edge that enters WB.
    always_comb begin
        result = '0;
        case (op_q)
            OP_MUL:   result = prod_nxt[WIDTH-1:0];
            OP_MULHU: result = prod_nxt[2*WIDTH-1:WIDTH];
            OP_DIVU:  result = (b_q == '0) ? DIV0_QUOTIENT[WIDTH-1:0] : quo_nxt;
            OP_REMU:  result = rem_nxt;
            default:  result = '0;
        endcase
    end

    // Next-state logic: IDLE -> CALC on accept, CALC -> WB after the last
    // iteration, WB always returns to IDLE so WB never overlaps an accept.
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:  if (accept)    state_d = S_CALC;
            S_CALC:  if (last_step) state_d = S_WB;
            S_WB:                   state_d = S_IDLE;
            default:                state_d = S_IDLE;
        endcase
    end

    // Operand capture, iteration registers and write-back beat generation.
    always_comb begin
        cnt_d  = cnt_q;
        op_d   = op_q;
        a_d    = a_q;
        b_d    = b_q;
        rd_d   = rd_q;
        prod_d = prod_q;
        quo_d  = quo_q;
        rem_d  = rem_q;
        wd3_d  = wd3_q;
        wa3_d  = wa3_q;
        we3_d  = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (accept) begin
                    op_d   = op_e'(op);
                    a_d    = rs1_val;
                    b_d    = rs2_val;
                    rd_d   = rd_addr;
                    // Multiplier in the low half of the product; dividend
                    // starts in the quotient register and shifts out MSB first.
                    prod_d = {{WIDTH{1'b0}}, rs2_val};
                    quo_d  = rs1_val;
                    rem_d  = '0;
                    cnt_d  = '0;
                end
            end
            S_CALC: begin
                prod_d = prod_nxt;
                quo_d  = quo_nxt;
                rem_d  = rem_nxt;
                cnt_d  = cnt_q + CNT_W'(1);
                if (last_step) begin
                    cnt_d = '0;
                    // x0 destination: the WB cycle is still spent but the
                    // result is dropped and wd3/wa3 keep their old values.
                    if (rd_q != '0) begin
                        we3_d = 1'b1;
                        wa3_d = rd_q;
                        wd3_d = result;
                    end
                end
            end
            default: ;
        endcase
    end

    // State and datapath registers; synchronous active-low reset aborts any
    // operation in flight without issuing a write.
    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            op_q    <= OP_MUL;
            a_q     <= '0;
            b_q     <= '0;
            rd_q    <= '0;
            prod_q  <= '0;
            quo_q   <= '0;
            rem_q   <= '0;
            wd3_q   <= '0;
            wa3_q   <= '0;
            we3_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            op_q    <= op_d;
            a_q     <= a_d;
            b_q     <= b_d;
            rd_q    <= rd_d;
            prod_q  <= prod_d;
            quo_q   <= quo_d;
            rem_q   <= rem_d;
            wd3_q   <= wd3_d;
            wa3_q   <= wa3_d;
            we3_q   <= we3_d;
        end
    end

endmodule : muldiv_exec_unit
`default_nettype wire

// File: tb/tb_muldiv_exec_unit.sv
`default_nettype none
// ============================================================================
//  Module      : tb_muldiv_exec_unit
//  Description : Self-checking bench for muldiv_exec_unit: a table of directed
//                operations with hand-computed results, plus sequences for
//                reset abort and back-to-back requests.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_muldiv_exec_unit;
    import muldiv_pkg::*;

    localparam int WIDTH  = 8;
    localparam int ADDR_W = 5;
    localparam int NVEC   = 13;

    typedef struct packed {
        logic [1:0]        op;
        logic [WIDTH-1:0]  a;
        logic [WIDTH-1:0]  b;
        logic [ADDR_W-1:0] rd;
        logic [WIDTH-1:0]  exp_wd;
        logic              exp_we;
    } vec_t;

    logic              clk = 1'b0;
    logic              rst;
    logic              in_valid;
    logic              in_ready;
    logic [1:0]        op_in;
    logic [WIDTH-1:0]  rs1_val;
    logic [WIDTH-1:0]  rs2_val;
    logic [ADDR_W-1:0] rd_addr;
    logic [WIDTH-1:0]  wd3;
    logic [ADDR_W-1:0] wa3;
    logic              we3;
    logic              busy;

    int n_checks = 0;
    int n_errors = 0;

    vec_t vecs [NVEC];

    muldiv_exec_unit #(
        .WIDTH    (WIDTH),
        .ADDR_W   (ADDR_W)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .op       (op_in),
        .rs1_val  (rs1_val),
        .rs2_val  (rs2_val),
        .rd_addr  (rd_addr),
        .wd3      (wd3),
        .wa3      (wa3),
        .we3      (we3),
        .busy     (busy)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // Issue one op from IDLE, scramble the inputs right after acceptance, and
    // watch 13 cycles: write pulse timing/contents, busy span, in_ready return.
    task automatic run_op(input vec_t v, input int idx);
        int               first_we;
        int               pulses;
        int               busy_cnt;
        logic [WIDTH-1:0] got_wd;
        logic [ADDR_W-1:0] got_wa;
        logic             rdy9;
        first_we = -1;
        pulses   = 0;
        busy_cnt = 0;
        got_wd   = '0;
        got_wa   = '0;
        rdy9     = 1'b0;
        @(negedge clk);
        check($sformatf("vec%0d_ready_before", idx), 32'(in_ready), 32'd1);
        in_valid = 1'b1;
        op_in    = v.op;
        rs1_val  = v.a;
        rs2_val  = v.b;
        rd_addr  = v.rd;
        for (int n = 0; n <= 12; n++) begin
            @(negedge clk);
            if (n == 0) begin
                in_valid = 1'b0;
                op_in    = ~v.op;
                rs1_val  = ~v.a;
                rs2_val  = v.a;
                rd_addr  = 5'd31;
            end
            if (busy) busy_cnt++;
            if (we3) begin
                pulses++;
                if (first_we < 0) begin
                    first_we = n;
                    got_wd   = wd3;
                    got_wa   = wa3;
                end
            end
            if (n == 9) rdy9 = in_ready;
        end
        check($sformatf("vec%0d_pulses", idx), 32'(pulses), v.exp_we ? 32'd1 : 32'd0);
        check($sformatf("vec%0d_busy_cycles", idx), 32'(busy_cnt), 32'd9);
        check($sformatf("vec%0d_ready_after", idx), 32'(rdy9), 32'd1);
        if (v.exp_we) begin
            check($sformatf("vec%0d_latency", idx), 32'(first_we), 32'd8);
            check($sformatf("vec%0d_wd3", idx), 32'(got_wd), 32'(v.exp_wd));
            check($sformatf("vec%0d_wa3", idx), 32'(got_wa), 32'(v.rd));
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int               pulses;
        int               p_idx [2];
        logic [WIDTH-1:0] p_wd  [2];
        logic [ADDR_W-1:0] p_wa [2];
        logic             rdy8, rdy9;

        //            op        a      b      rd     exp_wd exp_we
        vecs[0]  = '{OP_MUL,   8'h0D, 8'h0B, 5'd3,  8'h8F, 1'b1};
        vecs[1]  = '{OP_MULHU, 8'hFF, 8'hFF, 5'd5,  8'hFE, 1'b1};
        vecs[2]  = '{OP_MUL,   8'hFF, 8'hFF, 5'd5,  8'h01, 1'b1};
        vecs[3]  = '{OP_DIVU,  8'hC8, 8'h07, 5'd2,  8'h1C, 1'b1};
        vecs[4]  = '{OP_REMU,  8'hC8, 8'h07, 5'd2,  8'h04, 1'b1};
        vecs[5]  = '{OP_DIVU,  8'h55, 8'h00, 5'd7,  8'hFF, 1'b1};
        vecs[6]  = '{OP_REMU,  8'h55, 8'h00, 5'd7,  8'h55, 1'b1};
        vecs[7]  = '{OP_MUL,   8'h03, 8'h04, 5'd0,  8'h00, 1'b0};
        vecs[8]  = '{OP_MULHU, 8'h80, 8'h02, 5'd9,  8'h01, 1'b1};
        vecs[9]  = '{OP_DIVU,  8'hFF, 8'h01, 5'd31, 8'hFF, 1'b1};
        vecs[10] = '{OP_REMU,  8'hFF, 8'h10, 5'd12, 8'h0F, 1'b1};
        vecs[11] = '{OP_DIVU,  8'h05, 8'h09, 5'd1,  8'h00, 1'b1};
        vecs[12] = '{OP_MUL,   8'h00, 8'h5A, 5'd4,  8'h00, 1'b1};

        rst      = 1'b0;
        in_valid = 1'b0;
        op_in    = 2'b00;
        rs1_val  = '0;
        rs2_val  = '0;
        rd_addr  = '0;

        // Reset state
        repeat (3) @(negedge clk);
        check("rst_busy",     32'(busy),     32'd0);
        check("rst_we3",      32'(we3),      32'd0);
        check("rst_wd3",      32'(wd3),      32'd0);
        check("rst_wa3",      32'(wa3),      32'd0);
        check("rst_in_ready", 32'(in_ready), 32'd1);
        rst = 1'b1;

        for (int i = 0; i < NVEC; i++) run_op(vecs[i], i);

        // Reset during CALC at cnt==4 aborts the operation.
        @(negedge clk);
        in_valid = 1'b1;
        op_in    = OP_MUL;
        rs1_val  = 8'h0D;
        rs2_val  = 8'h0B;
        rd_addr  = 5'd3;
        for (int n = 0; n <= 4; n++) begin
            @(negedge clk);
            if (n == 0) in_valid = 1'b0;
        end
        rst = 1'b0;
        @(negedge clk);
        check("abort_busy",     32'(busy),     32'd0);
        check("abort_we3",      32'(we3),      32'd0);
        check("abort_in_ready", 32'(in_ready), 32'd1);
        rst    = 1'b1;
        pulses = 0;
        for (int n = 0; n < 12; n++) begin
            @(negedge clk);
            if (we3) pulses++;
        end
        check("abort_no_write", 32'(pulses), 32'd0);
        run_op(vecs[0], 100);

        // in_valid held across two ops: second accepted only after first WB.
        @(negedge clk);
        in_valid = 1'b1;
        op_in    = OP_MUL;
        rs1_val  = 8'h0D;
        rs2_val  = 8'h0B;
        rd_addr  = 5'd3;
        pulses   = 0;
        p_idx    = '{-1, -1};
        p_wd     = '{8'h00, 8'h00};
        p_wa     = '{5'd0, 5'd0};
        rdy8     = 1'b1;
        rdy9     = 1'b0;
        for (int n = 0; n <= 22; n++) begin
            @(negedge clk);
            if (n == 0) begin
                op_in   = OP_DIVU;
                rs1_val = 8'hC8;
                rs2_val = 8'h07;
                rd_addr = 5'd2;
            end
            if (n == 10) in_valid = 1'b0;
            if (n == 8) rdy8 = in_ready;
            if (n == 9) rdy9 = in_ready;
            if (we3) begin
                if (pulses < 2) begin
                    p_idx[pulses] = n;
                    p_wd[pulses]  = wd3;
                    p_wa[pulses]  = wa3;
                end
                pulses++;
            end
        end
        check("b2b_pulses",    32'(pulses),   32'd2);
        check("b2b_ready_wb",  32'(rdy8),     32'd0);
        check("b2b_ready_idle",32'(rdy9),     32'd1);
        check("b2b_p0_cycle",  32'(p_idx[0]), 32'd8);
        check("b2b_p0_wd3",    32'(p_wd[0]),  32'h8F);
        check("b2b_p0_wa3",    32'(p_wa[0]),  32'd3);
        check("b2b_p1_cycle",  32'(p_idx[1]), 32'd18);
        check("b2b_p1_wd3",    32'(p_wd[1]),  32'h1C);
        check("b2b_p1_wa3",    32'(p_wa[1]),  32'd2);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule : tb_muldiv_exec_unit
`default_nettype wire
